// File: rtl/calc_display_pkg.sv
// Shared display definitions: scan FSM states, segment constants and BCD-to-7-segment decode.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package calc_display_pkg;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            // Non-BCD codes show a dash so corrupted values are visible rather than garbled
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit BCD to active-low seven-segment decoder; codes 10-15 render as a dash.
module seg7_decoder
    import calc_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure combinational lookup through the shared package function
    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/display_scan_controller.sv
// Three-digit multiplexed seven-segment scan controller with frame-atomic value swap.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_controller
    import calc_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 500000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [11:0] load_digits,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  digit,
    output logic        frame_done
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    scan_state_t       state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        digit_r;
    logic [11:0]       disp_digits_r;
    logic [11:0]       pend_digits_r;
    logic              pend_valid_r;

    logic              frame_end_s;
    logic              accept_s;
    logic [3:0]        cur_bcd_s;
    logic [6:0]        dec_seg_s;
    logic              blank_digit_s;

    assign frame_end_s = (state_r == SCAN_SHOW) && (cnt_r == DWELL_LAST) && (digit_r == 2'd2);
    assign accept_s    = load_valid && !pend_valid_r;

    // Scan FSM: blank gap, then dwell on the selected digit, advancing 0->1->2->0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= SCAN_BLANK;
            cnt_r   <= '0;
            digit_r <= 2'd0;
        end else begin
            case (state_r)
                SCAN_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_r <= SCAN_SHOW;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                SCAN_SHOW: begin
                    if (cnt_r == DWELL_LAST) begin
                        state_r <= SCAN_BLANK;
                        cnt_r   <= '0;
                        digit_r <= (digit_r == 2'd2) ? 2'd0 : digit_r + 2'd1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= SCAN_BLANK;
                    cnt_r   <= '0;
                    digit_r <= 2'd0;
                end
            endcase
        end
    end

    // Pending buffer and display register; a swap and an accept can never share a cycle
    // because accepting requires the buffer to be empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_digits_r <= 12'h000;
            pend_valid_r  <= 1'b0;
            disp_digits_r <= 12'h000;
        end else if (frame_end_s && pend_valid_r) begin
            disp_digits_r <= pend_digits_r;
            pend_valid_r  <= 1'b0;
        end else if (accept_s) begin
            pend_digits_r <= load_digits;
            pend_valid_r  <= 1'b1;
        end else begin
            pend_valid_r  <= pend_valid_r;
        end
    end

    // Select the nibble of the digit currently being scanned
    always_comb begin
        cur_bcd_s = 4'd0;
        case (digit_r)
            2'd0:    cur_bcd_s = disp_digits_r[3:0];
            2'd1:    cur_bcd_s = disp_digits_r[7:4];
            2'd2:    cur_bcd_s = disp_digits_r[11:8];
            default: cur_bcd_s = 4'd0;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .bcd (cur_bcd_s),
        .seg (dec_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Suppress leading zeros; digit 0 always shows so zero still reads "0"
    always_comb begin
        blank_digit_s = 1'b0;
        if (digit_r == 2'd2) begin
            blank_digit_s = (disp_digits_r[11:8] == 4'd0);
        end else if (digit_r == 2'd1) begin
            blank_digit_s = (disp_digits_r[11:8] == 4'd0) && (disp_digits_r[7:4] == 4'd0);
        end else begin
            blank_digit_s = 1'b0;
        end
    end
`else
    // Every digit is shown, leading zeros included
    always_comb begin
        blank_digit_s = 1'b0;
    end
`endif

    // Pin drive derived only from registers, so an toggles solely on state edges
    always_comb begin
        an  = 3'b111;
        seg = SEG_BLANK;
        if ((state_r == SCAN_SHOW) && !blank_digit_s) begin
            case (digit_r)
                2'd0:    an = 3'b110;
                2'd1:    an = 3'b101;
                2'd2:    an = 3'b011;
                default: an = 3'b111;
            endcase
            seg = dec_seg_s;
        end else begin
            an  = 3'b111;
            seg = SEG_BLANK;
        end
    end

    assign digit      = digit_r;
    assign frame_done = frame_end_s;
    assign load_ready = !pend_valid_r;

endmodule
